// File: rtl/dcache_store_port.sv
// Store-commit side of a small direct-mapped, write-back, write-allocate data cache.
// Committed stores are merged into the line array. Misses evict dirty victims and refill
// the line over a 128-bit memory handshake. A combinational load-lookup port reads the array.
module dcache_store_port #(
    parameter int NUM_LINES = 4,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_write_to_cache,
    input  logic [31:0]          in_addr,
    input  logic [31:0]          in_data,
    input  logic [2:0]           in_funct3,
    input  logic                 in_load_req,
    input  logic [31:0]          in_load_addr,
    output logic                 out_load_hit,
    output logic [31:0]          out_load_data,
    output logic                 out_busy,
    output logic                 out_done,
    output logic                 out_misaligned,
    output logic                 out_mem_req,
    output logic                 out_mem_we,
    output logic [31:0]          out_mem_addr,
    output logic [LINE_BITS-1:0] out_mem_wdata,
    input  logic                 in_mem_ready,
    input  logic [LINE_BITS-1:0] in_mem_rdata
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = 32 - IDX_BITS - 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_WRITEBACK = 3'd2;
    localparam logic [2:0] ST_REFILL    = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 drop_q, drop_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_d [NUM_LINES];
    logic [LINE_BITS-1:0] line_q [NUM_LINES];
    logic [LINE_BITS-1:0] line_d [NUM_LINES];

    logic [IDX_BITS-1:0]  cur_idx;
    logic [TAG_BITS-1:0]  cur_tag;
    logic                 cur_hit;
    logic                 bad_store;
    logic [LINE_BITS-1:0] wr_pattern;
    logic [LINE_BITS-1:0] wr_mask;
    logic [LINE_BITS-1:0] merged_line;

    logic [IDX_BITS-1:0]  load_idx;
    logic [TAG_BITS-1:0]  load_tag;
    logic                 unused_load_lsbs;

    assign cur_idx = addr_q[IDX_BITS+3:4];
    assign cur_tag = addr_q[31:IDX_BITS+4];
    assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // Classify the captured store: unknown sizes and unaligned halves/words are dropped.
    always_comb begin
        bad_store = 1'b0;
        case (funct3_q)
            3'b000:  bad_store = 1'b0;
            3'b001:  bad_store = addr_q[0];
            3'b010:  bad_store = (addr_q[1:0] != 2'b00);
            default: bad_store = 1'b1;
        endcase
    end

    // Build the byte mask and replicated data so the store lands at its byte offset.
    always_comb begin
        logic [3:0] kb;
        kb         = 4'd0;
        wr_pattern = '0;
        wr_mask    = '0;
        case (funct3_q)
            3'b000:  wr_pattern = {16{data_q[7:0]}};
            3'b001:  wr_pattern = {8{data_q[15:0]}};
            3'b010:  wr_pattern = {4{data_q}};
            default: wr_pattern = '0;
        endcase
        for (int k = 0; k < 16; k++) begin
            kb = 4'(k);
            case (funct3_q)
                3'b000:  wr_mask[8*k +: 8] = (kb == addr_q[3:0]) ? 8'hFF : 8'h00;
                3'b001:  wr_mask[8*k +: 8] = (kb[3:1] == addr_q[3:1]) ? 8'hFF : 8'h00;
                3'b010:  wr_mask[8*k +: 8] = (kb[3:2] == addr_q[3:2]) ? 8'hFF : 8'h00;
                default: wr_mask[8*k +: 8] = 8'h00;
            endcase
        end
        merged_line = (line_q[cur_idx] & ~wr_mask) | (wr_pattern & wr_mask);
    end

    // Next-state logic for the store FSM and the line array.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        drop_d   = drop_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        tag_d    = tag_q;
        line_d   = line_q;
        case (state_q)
            ST_IDLE: begin
                if (in_write_to_cache) begin
                    addr_d   = in_addr;
                    data_d   = in_data;
                    funct3_d = in_funct3;
                    drop_d   = 1'b0;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                drop_d = bad_store;
                if (bad_store || cur_hit) begin
                    state_d = ST_WRITE;
                end else if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (in_mem_ready) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (in_mem_ready) begin
                    line_d[cur_idx]  = in_mem_rdata;
                    tag_d[cur_idx]   = cur_tag;
                    valid_d[cur_idx] = 1'b1;
                    dirty_d[cur_idx] = 1'b0;
                    state_d          = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!drop_q) begin
                    line_d[cur_idx]  = merged_line;
                    dirty_d[cur_idx] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and array registers; reset abandons any transaction and invalidates every line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            funct3_q <= '0;
            drop_q   <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            funct3_q <= funct3_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            line_q   <= line_d;
        end
    end

    // Handshake and memory outputs decode straight from the state and captured store.
    always_comb begin
        out_busy       = (state_q != ST_IDLE);
        out_done       = (state_q == ST_WRITE);
        out_misaligned = (state_q == ST_WRITE) && drop_q;
        out_mem_req    = 1'b0;
        out_mem_we     = 1'b0;
        out_mem_addr   = '0;
        out_mem_wdata  = '0;
        if (state_q == ST_WRITEBACK) begin
            out_mem_req   = 1'b1;
            out_mem_we    = 1'b1;
            out_mem_addr  = {tag_q[cur_idx], cur_idx, 4'b0000};
            out_mem_wdata = line_q[cur_idx];
        end else if (state_q == ST_REFILL) begin
            out_mem_req  = 1'b1;
            out_mem_addr = {addr_q[31:4], 4'b0000};
        end
    end

    assign load_idx         = in_load_addr[IDX_BITS+3:4];
    assign load_tag         = in_load_addr[31:IDX_BITS+4];
    assign unused_load_lsbs = ^in_load_addr[1:0];

    // Load lookup sees the array as it stands before this cycle's update edge.
    always_comb begin
        out_load_hit  = in_load_req && valid_q[load_idx] && (tag_q[load_idx] == load_tag);
        out_load_data = '0;
        if (out_load_hit) begin
            out_load_data = line_q[load_idx][{in_load_addr[3:2], 5'b00000} +: 32];
        end
    end

endmodule

// File: tb/tb_dcache_store_port.sv
// Self-checking bench for dcache_store_port: the bench plays store buffer and memory,
// queues the expected completions and memory requests, and pops them as the DUT responds.
module tb_dcache_store_port;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wlo;
    } memExp_t;

    logic         clk;
    logic         reset;
    logic         in_write_to_cache;
    logic [31:0]  in_addr;
    logic [31:0]  in_data;
    logic [2:0]   in_funct3;
    logic         in_load_req;
    logic [31:0]  in_load_addr;
    logic         out_load_hit;
    logic [31:0]  out_load_data;
    logic         out_busy;
    logic         out_done;
    logic         out_misaligned;
    logic         out_mem_req;
    logic         out_mem_we;
    logic [31:0]  out_mem_addr;
    logic [127:0] out_mem_wdata;
    logic         in_mem_ready;
    logic [127:0] in_mem_rdata;

    int assertCount = 0;
    int failCount   = 0;

    logic    doneQ[$];
    memExp_t memQ[$];

    int lat;
    int memReqs;

    dcache_store_port #(.NUM_LINES(4), .LINE_BITS(128)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_write_to_cache (in_write_to_cache),
        .in_addr           (in_addr),
        .in_data           (in_data),
        .in_funct3         (in_funct3),
        .in_load_req       (in_load_req),
        .in_load_addr      (in_load_addr),
        .out_load_hit      (out_load_hit),
        .out_load_data     (out_load_data),
        .out_busy          (out_busy),
        .out_done          (out_done),
        .out_misaligned    (out_misaligned),
        .out_mem_req       (out_mem_req),
        .out_mem_we        (out_mem_we),
        .out_mem_addr      (out_mem_addr),
        .out_mem_wdata     (out_mem_wdata),
        .in_mem_ready      (in_mem_ready),
        .in_mem_rdata      (in_mem_rdata)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value differs
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one store request at an idle cycle, holds it through the accepting edge,
    // and queues the completion the bench expects to see
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                                 input logic expMis);
        int guard;
        guard = 0;
        @(negedge clk);
        while (out_busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("idle_timeout", 128'(out_busy), 128'(0));
        in_write_to_cache = 1'b1;
        in_addr           = addr;
        in_data           = data;
        in_funct3         = f3;
        @(posedge clk);
        @(negedge clk);
        in_write_to_cache = 1'b0;
        doneQ.push_back(expMis);
    endtask

    // Acts as memory and waits for the queued completion, popping expectations as the DUT answers
    task automatic waitDone(input string tag, input int delay, input logic [127:0] rdata,
                            input logic spurious, output int latency, output int reqs);
        logic    reqActive;
        logic    gotDone;
        int      waitCnt;
        memExp_t e;
        reqActive = 1'b0;
        gotDone   = 1'b0;
        waitCnt   = 0;
        latency   = 1;
        reqs      = 0;
        for (int cyc = 0; cyc < 100 && !gotDone; cyc++) begin
            @(negedge clk);
            latency++;
            if (in_mem_ready) begin
                in_mem_ready = 1'b0;
                reqActive    = 1'b0;
            end
            if (out_mem_req && !reqActive) begin
                reqs++;
                reqActive = 1'b1;
                waitCnt   = 0;
                if (memQ.size() == 0) begin
                    checkOutput({tag, "_unexpected_mem_req"}, 128'(1), 128'(0));
                end else begin
                    e = memQ.pop_front();
                    checkOutput({tag, "_mem_we"}, 128'(out_mem_we), 128'(e.we));
                    checkOutput({tag, "_mem_addr"}, 128'(out_mem_addr), 128'(e.addr));
                    if (e.we) checkOutput({tag, "_mem_wdata"}, 128'(out_mem_wdata[31:0]), 128'(e.wlo));
                end
            end
            in_write_to_cache = 1'b0;
            if (reqActive) begin
                if (waitCnt == delay) begin
                    in_mem_ready = 1'b1;
                    in_mem_rdata = rdata;
                end else begin
                    waitCnt++;
                    if (spurious) begin
                        in_write_to_cache = 1'b1;
                        in_addr           = 32'h0000_0060;
                        in_data           = 32'h7777_7777;
                        in_funct3         = 3'b010;
                    end
                end
            end
            if (out_done) begin
                gotDone = 1'b1;
                if (doneQ.size() == 0) begin
                    checkOutput({tag, "_unexpected_done"}, 128'(1), 128'(0));
                end else begin
                    checkOutput({tag, "_misaligned"}, 128'(out_misaligned), 128'(doneQ.pop_front()));
                end
            end
        end
        in_write_to_cache = 1'b0;
        if (!gotDone) checkOutput({tag, "_done_timeout"}, 128'(0), 128'(1));
    endtask

    // Drives a load lookup away from the clock edge and checks hit and data
    task automatic checkLoad(input string tag, input logic [31:0] addr, input logic expHit, input logic [31:0] expData);
        in_load_req  = 1'b1;
        in_load_addr = addr;
        #1;
        checkOutput({tag, "_hit"}, 128'(out_load_hit), 128'(expHit));
        checkOutput({tag, "_data"}, 128'(out_load_data), 128'(expData));
        in_load_req = 1'b0;
    endtask

    // Main stimulus sequence
    initial begin
        int extraDone;
        int busyCycles;
        int guard;
        reset             = 1'b1;
        in_write_to_cache = 1'b0;
        in_addr           = '0;
        in_data           = '0;
        in_funct3         = '0;
        in_load_req       = 1'b0;
        in_load_addr      = '0;
        in_mem_ready      = 1'b0;
        in_mem_rdata      = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", 128'(out_busy), 128'(0));
        checkOutput("rst_done", 128'(out_done), 128'(0));
        checkOutput("rst_mem_req", 128'(out_mem_req), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        checkLoad("rst_load", 32'h0000_0040, 1'b0, 32'h0);

        $display("[TB] SW miss with clean refill");
        memQ.push_back('{we: 1'b0, addr: 32'h0000_0040, wlo: 32'h0});
        applyStimulus(32'h0000_0040, 32'hDEAD_BEEF, 3'b010, 1'b0);
        waitDone("sw_miss", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("sw_miss_reqs", 128'(memReqs), 128'(1));
        @(negedge clk);
        checkLoad("load40", 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);

        $display("[TB] SB hit");
        applyStimulus(32'h0000_0041, 32'h0000_00AA, 3'b000, 1'b0);
        waitDone("sb_hit", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("sb_hit_lat", 128'(lat), 128'(2));
        checkOutput("sb_hit_reqs", 128'(memReqs), 128'(0));
        @(negedge clk);
        checkLoad("load40_sb", 32'h0000_0040, 1'b1, 32'hDEAD_AAEF);

        $display("[TB] SW dirty miss");
        memQ.push_back('{we: 1'b1, addr: 32'h0000_0040, wlo: 32'hDEAD_AAEF});
        memQ.push_back('{we: 1'b0, addr: 32'h0000_0080, wlo: 32'h0});
        applyStimulus(32'h0000_0080, 32'h1234_5678, 3'b010, 1'b0);
        waitDone("dirty_miss", 2, 128'hCAFEF00D_0BADC0DE_11223344_55667788, 1'b0, lat, memReqs);
        checkOutput("dirty_miss_reqs", 128'(memReqs), 128'(2));
        @(negedge clk);
        checkLoad("load80", 32'h0000_0080, 1'b1, 32'h1234_5678);
        checkLoad("load84", 32'h0000_0084, 1'b1, 32'h1122_3344);
        checkLoad("load8c", 32'h0000_008C, 1'b1, 32'hCAFE_F00D);
        checkLoad("load40_evicted", 32'h0000_0040, 1'b0, 32'h0);

        $display("[TB] SH hit at upper half");
        applyStimulus(32'h0000_0086, 32'h0000_BEEF, 3'b001, 1'b0);
        waitDone("sh_hit", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("sh_hit_lat", 128'(lat), 128'(2));
        @(negedge clk);
        checkLoad("load84_sh", 32'h0000_0084, 1'b1, 32'hBEEF_3344);

        $display("[TB] Dropped stores");
        applyStimulus(32'h0000_0043, 32'h0000_5555, 3'b001, 1'b1);
        waitDone("sh_mis", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("sh_mis_lat", 128'(lat), 128'(2));
        checkOutput("sh_mis_reqs", 128'(memReqs), 128'(0));
        applyStimulus(32'h0000_0082, 32'h9999_9999, 3'b010, 1'b1);
        waitDone("sw_mis", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("sw_mis_reqs", 128'(memReqs), 128'(0));
        applyStimulus(32'h0000_0080, 32'h9999_9999, 3'b011, 1'b1);
        waitDone("illegal", 0, 128'h0, 1'b0, lat, memReqs);
        checkOutput("illegal_reqs", 128'(memReqs), 128'(0));
        @(negedge clk);
        checkLoad("load80_kept", 32'h0000_0080, 1'b1, 32'h1234_5678);
        checkLoad("load84_kept", 32'h0000_0084, 1'b1, 32'hBEEF_3344);

        $display("[TB] Request while busy is ignored");
        memQ.push_back('{we: 1'b0, addr: 32'h0000_0050, wlo: 32'h0});
        applyStimulus(32'h0000_0050, 32'hA5A5_A5A5, 3'b010, 1'b0);
        waitDone("busy_ign", 5, 128'h0, 1'b1, lat, memReqs);
        extraDone  = 0;
        busyCycles = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_done) extraDone++;
            if (out_busy) busyCycles++;
        end
        checkOutput("busy_ign_done", 128'(extraDone), 128'(0));
        checkOutput("busy_ign_busy", 128'(busyCycles), 128'(0));
        checkLoad("load50", 32'h0000_0050, 1'b1, 32'hA5A5_A5A5);
        checkLoad("load60_miss", 32'h0000_0060, 1'b0, 32'h0);
        checkOutput("sb_empty", 128'(doneQ.size() + memQ.size()), 128'(0));

        $display("[TB] Reset during writeback");
        applyStimulus(32'h0000_00C0, 32'h0BAD_0BAD, 3'b010, 1'b0);
        guard = 0;
        while (!out_mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wb_seen", 128'(out_mem_req), 128'(1));
        checkOutput("wb_we", 128'(out_mem_we), 128'(1));
        checkOutput("wb_addr", 128'(out_mem_addr), 128'(32'h0000_0080));
        reset = 1'b1;
        #1;
        checkOutput("rst_wb_mem_req", 128'(out_mem_req), 128'(0));
        checkOutput("rst_wb_busy", 128'(out_busy), 128'(0));
        doneQ.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkLoad("load40_rst", 32'h0000_0040, 1'b0, 32'h0);
        checkLoad("load80_rst", 32'h0000_0080, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
